// File: rtl/ntsc_pkg.sv
// Shared NTSC constants, pipeline stage records and small helpers for the composite path.
// The timing generator imports the same level constants.
package ntsc_pkg;

   localparam logic [7:0] BLANK_LEVEL = 8'd72;
   localparam logic [7:0] BLACK_LEVEL = 8'd89;
   localparam logic [7:0] WHITE_LEVEL = 8'd255;
   localparam logic [7:0] SYNC_LEVEL  = 8'd0;
   localparam logic [7:0] BURST_AMP   = 8'd20;

   localparam logic [7:0] Y_COEF_R = 8'd77;
   localparam logic [7:0] Y_COEF_G = 8'd150;
   localparam logic [7:0] Y_COEF_B = 8'd29;
   localparam logic [7:0] U_COEF   = 8'd126;
   localparam logic [7:0] V_COEF   = 8'd224;

   localparam logic [7:0] LUMA_SPAN = WHITE_LEVEL - BLACK_LEVEL;

   // Subcarrier phase at 4x fsc: one sample per quadrant.
   typedef enum logic [1:0] {
      PH_PU = 2'd0,
      PH_PV = 2'd1,
      PH_NU = 2'd2,
      PH_NV = 2'd3
   } phase_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   typedef struct packed {
      logic [7:0] base;
      logic       hsync;
      logic       vsync;
      logic       burst;
      logic       act;
      logic       mono;
      logic [7:0] pixel;
      phase_e     phase;
   } s1_t;

   typedef struct packed {
      logic [7:0] base;
      logic       hsync;
      logic       vsync;
      logic       burst;
      logic       act;
      logic       mono;
      logic [7:0] luma;
      logic [8:0] u;
      logic [8:0] v;
      phase_e     phase;
   } s2_t;

   function automatic rgb888_t expand_rgb332(input logic [7:0] pix);
      rgb888_t o;
      o.r = {pix[7:5], pix[7:5], pix[7:6]};
      o.g = {pix[4:2], pix[4:2], pix[4:3]};
      o.b = {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
      return o;
   endfunction

   function automatic logic [7:0] clamp_u8(input logic signed [10:0] s);
      if (s < 11'sd0) begin
         return 8'd0;
      end else if (s > 11'sd255) begin
         return 8'd255;
      end else begin
         return s[7:0];
      end
   endfunction

endpackage

// File: rtl/ntsc_rgb332_to_yuv.sv
// Combinational RGB332 -> Y (unsigned 8-bit) and scaled U/V (signed 9-bit, floor shift).
module ntsc_rgb332_to_yuv
   import ntsc_pkg::*;
(
   input  logic              [7:0] pixel_i,
   output logic              [7:0] y_o,
   output logic signed       [8:0] u_o,
   output logic signed       [8:0] v_o
);

   rgb888_t            rgb_s;
   logic        [15:0] y_acc_s;
   logic        [7:0]  y_s;
   logic signed [9:0]  bmy_s;
   logic signed [9:0]  rmy_s;
   logic signed [17:0] u_prod_s;
   logic signed [17:0] v_prod_s;

   // Colour-space conversion; >>> on the signed products gives the floor behaviour.
   always_comb begin
      rgb_s    = expand_rgb332(pixel_i);
      y_acc_s  = 16'(rgb_s.r) * 16'(Y_COEF_R)
               + 16'(rgb_s.g) * 16'(Y_COEF_G)
               + 16'(rgb_s.b) * 16'(Y_COEF_B);
      y_s      = 8'(y_acc_s >> 8);
      bmy_s    = $signed({2'b00, rgb_s.b}) - $signed({2'b00, y_s});
      rmy_s    = $signed({2'b00, rgb_s.r}) - $signed({2'b00, y_s});
      u_prod_s = 18'(bmy_s) * $signed({10'd0, U_COEF});
      v_prod_s = 18'(rmy_s) * $signed({10'd0, V_COEF});
      y_o      = y_s;
      u_o      = 9'(u_prod_s >>> 8);
      v_o      = 9'(v_prod_s >>> 8);
   end

endmodule

// File: rtl/ntsc_composite_encoder.sv
// Final composite stage: 3-deep pipeline from timing flags + RGB332 pixel to the 8-bit DAC sample,
// with QAM chroma at 4x fsc and a free-running phase that inverts chroma on alternate lines.
module ntsc_composite_encoder
   import ntsc_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] ntsc_base,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       colorburst,
   input  logic       hactive,
   input  logic       vactive,
   input  logic [7:0] pixel_rgb,
   input  logic       mono,
   output logic [7:0] composite,
   output logic       sync_out
);

   phase_e             phase_q;
   phase_e             phase_d;
   s1_t                s1_q;
   s1_t                s1_d;
   s2_t                s2_q;
   s2_t                s2_d;

   logic        [7:0]  y_s;
   logic signed [8:0]  u_s;
   logic signed [8:0]  v_s;
   logic        [15:0] luma_prod_s;

   logic signed [10:0] chroma_s;
   logic signed [10:0] burst_s;
   logic signed [10:0] sum_s;
   logic        [7:0]  composite_d;
   logic        [7:0]  composite_q;
   logic               sync_d;
   logic               sync_q;

   // S1 capture; the phase never restarts per line, so a 910-clk line advances it by two.
   always_comb begin
      s1_d       = '0;
      s1_d.base  = ntsc_base;
      s1_d.hsync = hsync;
      s1_d.vsync = vsync;
      s1_d.burst = colorburst;
      s1_d.act   = hactive & vactive;
      s1_d.mono  = mono;
      s1_d.pixel = pixel_rgb;
      s1_d.phase = phase_q;
      phase_d    = phase_e'(phase_q + 2'd1);
   end

   ntsc_rgb332_to_yuv u_yuv (
      .pixel_i (s1_q.pixel),
      .y_o     (y_s),
      .u_o     (u_s),
      .v_o     (v_s)
   );

   // S2: luma scaled into the black..white DAC range, chroma terms forwarded.
   always_comb begin
      s2_d        = '0;
      luma_prod_s = 16'(y_s) * 16'(LUMA_SPAN);
      s2_d.base   = s1_q.base;
      s2_d.hsync  = s1_q.hsync;
      s2_d.vsync  = s1_q.vsync;
      s2_d.burst  = s1_q.burst;
      s2_d.act    = s1_q.act;
      s2_d.mono   = s1_q.mono;
      s2_d.luma   = BLACK_LEVEL + 8'(luma_prod_s >> 8);
      s2_d.u      = u_s;
      s2_d.v      = v_s;
      s2_d.phase  = s1_q.phase;
   end

   // S3: modulate, select by absolute priority sync > burst > active > base, then clamp.
   always_comb begin
      chroma_s = 11'sd0;
      burst_s  = 11'sd0;
      if (s2_q.mono) begin
         chroma_s = 11'sd0;
         burst_s  = 11'sd0;
      end else begin
         case (s2_q.phase)
            PH_PU: begin
               chroma_s = 11'($signed(s2_q.u));
               burst_s  = -$signed({3'b000, BURST_AMP});
            end
            PH_PV: begin
               chroma_s = 11'($signed(s2_q.v));
               burst_s  = 11'sd0;
            end
            PH_NU: begin
               chroma_s = -11'($signed(s2_q.u));
               burst_s  = $signed({3'b000, BURST_AMP});
            end
            PH_NV: begin
               chroma_s = -11'($signed(s2_q.v));
               burst_s  = 11'sd0;
            end
            default: begin
               chroma_s = 11'sd0;
               burst_s  = 11'sd0;
            end
         endcase
      end

      if (s2_q.hsync | s2_q.vsync) begin
         sum_s = $signed({3'b000, SYNC_LEVEL});
      end else if (s2_q.burst) begin
         sum_s = $signed({3'b000, BLANK_LEVEL}) + burst_s;
      end else if (s2_q.act) begin
         sum_s = $signed({3'b000, s2_q.luma}) + chroma_s;
      end else begin
         sum_s = $signed({3'b000, s2_q.base});
      end

      composite_d = clamp_u8(sum_s);
      sync_d      = s2_q.hsync | s2_q.vsync;
   end

   // Pipeline and phase state; outputs rest at sync level while in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q     <= PH_PU;
         s1_q        <= '0;
         s2_q        <= '0;
         composite_q <= SYNC_LEVEL;
         sync_q      <= 1'b1;
      end else begin
         phase_q     <= phase_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         composite_q <= composite_d;
         sync_q      <= sync_d;
      end
   end

   assign composite = composite_q;
   assign sync_out  = sync_q;

endmodule

// File: tb/tb_ntsc_composite_encoder.sv
// Directed bench for ntsc_composite_encoder: hand-computed DAC codes per phase, latency, priority,
// line-to-line chroma inversion and asynchronous reset mid-line.
module tb_ntsc_composite_encoder;

   logic       clk;
   logic       reset_n;
   logic [7:0] ntsc_base;
   logic       hsync;
   logic       vsync;
   logic       colorburst;
   logic       hactive;
   logic       vactive;
   logic [7:0] pixel_rgb;
   logic       mono;
   logic [7:0] composite;
   logic       sync_out;

   int vectors     = 0;
   int miscompares = 0;
   int edges       = 0;

   logic [7:0] exp_blue  [4] = '{8'd218, 8'd82, 8'd0, 8'd132};
   logic [7:0] exp_burst [4] = '{8'd52, 8'd72, 8'd92, 8'd72};
   logic [7:0] line_out  [2][910];
   int         ph0       [910];

   ntsc_composite_encoder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ntsc_base  (ntsc_base),
      .hsync      (hsync),
      .vsync      (vsync),
      .colorburst (colorburst),
      .hactive    (hactive),
      .vactive    (vactive),
      .pixel_rgb  (pixel_rgb),
      .mono       (mono),
      .composite  (composite),
      .sync_out   (sync_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic set_idle();
      ntsc_base  = 8'd72;
      hsync      = 1'b0;
      vsync      = 1'b0;
      colorburst = 1'b0;
      hactive    = 1'b0;
      vactive    = 1'b0;
      pixel_rgb  = 8'h00;
      mono       = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_idle();
      repeat (3) tick();
      vectors++;
      if (composite !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_composite: got %0d expected 0", composite);
      end
      vectors++;
      if (sync_out !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_sync_out: got %0b expected 1", sync_out);
      end
      vectors++;
      if (dut.phase_q !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_phase: got %0d expected 0", dut.phase_q);
      end
   endtask

   task automatic test_sync_phase();
      set_idle();
      hsync   = 1'b1;
      reset_n = 1'b1;
      edges   = 0;
      vectors++;
      if (dut.phase_q !== 2'd0) begin
         miscompares++;
         $display("FAIL phase_start: got %0d expected 0", dut.phase_q);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         vectors++;
         if (dut.phase_q !== 2'(i % 4)) begin
            miscompares++;
            $display("FAIL phase_step%0d: got %0d expected %0d", i, dut.phase_q, i % 4);
         end
         if (i >= 3) begin
            vectors++;
            if (composite !== 8'd0 || sync_out !== 1'b1) begin
               miscompares++;
               $display("FAIL hsync_out: got %0d/%0b expected 0/1", composite, sync_out);
            end
         end
      end
      set_idle();
      vsync     = 1'b1;
      hactive   = 1'b1;
      vactive   = 1'b1;
      pixel_rgb = 8'hFF;
      repeat (3) tick();
      vectors++;
      if (composite !== 8'd0 || sync_out !== 1'b1) begin
         miscompares++;
         $display("FAIL vsync_over_act: got %0d/%0b expected 0/1", composite, sync_out);
      end
   endtask

   task automatic test_luma();
      logic [7:0] exp_l [3] = '{8'd89, 8'd89, 8'd254};
      set_idle();
      hactive   = 1'b1;
      vactive   = 1'b1;
      pixel_rgb = 8'h00;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (composite !== 8'd89 || sync_out !== 1'b0) begin
            miscompares++;
            $display("FAIL black: got %0d/%0b expected 89/0", composite, sync_out);
         end
      end
      pixel_rgb = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (composite !== exp_l[i]) begin
            miscompares++;
            $display("FAIL latency_clk%0d: got %0d expected %0d", i + 1, composite, exp_l[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (composite !== 8'd254) begin
            miscompares++;
            $display("FAIL white: got %0d expected 254", composite);
         end
      end
   endtask

   task automatic test_blue_chroma();
      set_idle();
      hactive   = 1'b1;
      vactive   = 1'b1;
      pixel_rgb = 8'h03;
      repeat (3) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (composite !== exp_blue[(edges - 3) % 4]) begin
            miscompares++;
            $display("FAIL blue_phase%0d: got %0d expected %0d", (edges - 3) % 4, composite,
                     exp_blue[(edges - 3) % 4]);
         end
      end
      mono = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (composite !== 8'd107) begin
            miscompares++;
            $display("FAIL blue_mono: got %0d expected 107", composite);
         end
      end
   endtask

   task automatic test_burst();
      set_idle();
      colorburst = 1'b1;
      hactive    = 1'b1;
      vactive    = 1'b1;
      pixel_rgb  = 8'hFF;
      repeat (3) tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if (composite !== exp_burst[(edges - 3) % 4] || sync_out !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_phase%0d: got %0d expected %0d", (edges - 3) % 4, composite,
                     exp_burst[(edges - 3) % 4]);
         end
      end
      mono = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (composite !== 8'd72) begin
            miscompares++;
            $display("FAIL burst_mono: got %0d expected 72", composite);
         end
      end
      mono  = 1'b0;
      hsync = 1'b1;
      repeat (3) tick();
      vectors++;
      if (composite !== 8'd0 || sync_out !== 1'b1) begin
         miscompares++;
         $display("FAIL sync_over_burst: got %0d/%0b expected 0/1", composite, sync_out);
      end
   endtask

   task automatic test_base();
      set_idle();
      pixel_rgb = 8'hFF;
      hactive   = 1'b1;
      repeat (3) tick();
      vectors++;
      if (composite !== 8'd72 || sync_out !== 1'b0) begin
         miscompares++;
         $display("FAIL base_blank: got %0d/%0b expected 72/0", composite, sync_out);
      end
      ntsc_base = 8'd90;
      repeat (3) tick();
      vectors++;
      if (composite !== 8'd90) begin
         miscompares++;
         $display("FAIL base_value: got %0d expected 90", composite);
      end
   endtask

   task automatic test_line_inversion();
      set_idle();
      hactive   = 1'b1;
      vactive   = 1'b1;
      pixel_rgb = 8'h03;
      repeat (3) tick();
      for (int j = 0; j < 1820; j++) begin
         tick();
         line_out[j / 910][j % 910] = composite;
         if (j < 910) ph0[j] = (edges - 3) % 4;
      end
      for (int h = 0; h < 910; h++) begin
         if (ph0[h] == 0) begin
            vectors++;
            if (line_out[0][h] !== 8'd218 || line_out[1][h] !== 8'd0) begin
               miscompares++;
               $display("FAIL line_inv_col%0d: got %0d,%0d expected 218,0", h, line_out[0][h],
                        line_out[1][h]);
            end
         end else if (ph0[h] == 1) begin
            vectors++;
            if (line_out[0][h] !== 8'd82 || line_out[1][h] !== 8'd132) begin
               miscompares++;
               $display("FAIL line_inv_col%0d: got %0d,%0d expected 82,132", h, line_out[0][h],
                        line_out[1][h]);
            end
         end
      end
   endtask

   task automatic test_reset_midline();
      logic [7:0] exp_r [6] = '{8'd0, 8'd0, 8'd218, 8'd82, 8'd0, 8'd132};
      set_idle();
      hactive   = 1'b1;
      vactive   = 1'b1;
      pixel_rgb = 8'hFF;
      repeat (3) tick();
      while (edges % 4 != 2) tick();
      vectors++;
      if (composite !== 8'd254) begin
         miscompares++;
         $display("FAIL pre_reset_white: got %0d expected 254", composite);
      end
      #3;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (composite !== 8'd0 || sync_out !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset: got %0d/%0b expected 0/1", composite, sync_out);
      end
      tick();
      vectors++;
      if (dut.phase_q !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_phase_mid: got %0d expected 0", dut.phase_q);
      end
      pixel_rgb = 8'h03;
      reset_n   = 1'b1;
      edges     = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (composite !== exp_r[i]) begin
            miscompares++;
            $display("FAIL post_reset_clk%0d: got %0d expected %0d", i + 1, composite, exp_r[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sync_phase();
      test_luma();
      test_blue_chroma();
      test_burst();
      test_base();
      test_line_inversion();
      test_reset_midline();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
